// File: rtl/alu32_arbiter_if.sv
// Request/response bundle between the two ALU clients and alu32_arbiter.
// The optional ALU_ARB_STICKY_OVF_EN sideband stays on the arbiter as plain ports.
interface alu32_arbiter_if;
   logic        req0;
   logic [2:0]  op0;
   logic [31:0] a0;
   logic [31:0] b0;
   logic        req1;
   logic [2:0]  op1;
   logic [31:0] a1;
   logic [31:0] b1;
   logic        gnt0;
   logic        gnt1;
   logic        done0;
   logic        done1;
   logic [31:0] result;
   logic        c;
   logic        n;
   logic        z;
   logic        v;
   logic        busy;

   modport master (
      output req0, op0, a0, b0, req1, op1, a1, b1,
      input  gnt0, gnt1, done0, done1, result, c, n, z, v, busy
   );

   modport slave (
      input  req0, op0, a0, b0, req1, op1, a1, b1,
      output gnt0, gnt1, done0, done1, result, c, n, z, v, busy
   );
endinterface

// File: rtl/alu32_arbiter.sv
// Two-requester arbiter around one 32-bit ALU: IDLE -> EXEC -> DONE per op.
// Optional macro ALU_ARB_STICKY_OVF_EN adds clr_sticky / ovf_sticky.
module alu32_arbiter #(
   parameter int unsigned PRIO_MODE = 0
) (
   input  logic          clk,
   input  logic          reset_n,
`ifdef ALU_ARB_STICKY_OVF_EN
   input  logic          clr_sticky,
   output logic          ovf_sticky,
`endif
   alu32_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        win_q, win_d;
   logic        rr_q, rr_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic        gnt0_q, gnt0_d;
   logic        gnt1_q, gnt1_d;
   logic        done0_q, done0_d;
   logic        done1_q, done1_d;
   logic [31:0] result_q, result_d;
   logic        c_q, c_d;
   logic        n_q, n_d;
   logic        z_q, z_d;
   logic        v_q, v_d;
   logic        busy_q, busy_d;
   logic        sticky_q, sticky_d;

   logic        win_sel;
   logic [31:0] alu_y;
   logic        alu_c;
   logic        alu_v;
   logic [32:0] alu_sum;

   // alu32: carry is the raw carry-out, so subtract reports c=1 for "no borrow".
   always_comb begin : alu32
      alu_sum = '0;
      alu_y   = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op_q)
         3'b000: alu_y = ~a_q;
         3'b001: alu_y = ~b_q;
         3'b010: alu_y = a_q & b_q;
         3'b011: alu_y = a_q | b_q;
         3'b100: alu_y = a_q ^ b_q;
         3'b101: alu_y = ~(a_q ^ b_q);
         3'b110: begin
            alu_sum = {1'b0, a_q} + {1'b0, b_q};
            alu_y   = alu_sum[31:0];
            alu_c   = alu_sum[32];
            alu_v   = (a_q[31] == b_q[31]) && (alu_y[31] != a_q[31]);
         end
         default: begin
            alu_sum = {1'b0, a_q} + {1'b0, ~b_q} + 33'd1;
            alu_y   = alu_sum[31:0];
            alu_c   = alu_sum[32];
            alu_v   = (a_q[31] != b_q[31]) && (alu_y[31] != a_q[31]);
         end
      endcase
   end

   // On a tie the requester that did not win last time goes next.
   always_comb begin
      if (bus.req0 && !bus.req1)      win_sel = 1'b0;
      else if (bus.req1 && !bus.req0) win_sel = 1'b1;
      else if (PRIO_MODE == 1)        win_sel = 1'b0;
      else                            win_sel = ~rr_q;
   end

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      rr_d     = rr_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      gnt0_d   = gnt0_q;
      gnt1_d   = gnt1_q;
      done0_d  = done0_q;
      done1_d  = done1_q;
      result_d = result_q;
      c_d      = c_q;
      n_d      = n_q;
      z_d      = z_q;
      v_d      = v_q;
      busy_d   = busy_q;
      sticky_d = sticky_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req0 || bus.req1) begin
               state_d = S_EXEC;
               win_d   = win_sel;
               op_d    = win_sel ? bus.op1 : bus.op0;
               a_d     = win_sel ? bus.a1  : bus.a0;
               b_d     = win_sel ? bus.b1  : bus.b0;
               gnt0_d  = ~win_sel;
               gnt1_d  = win_sel;
               busy_d  = 1'b1;
            end
         end
         S_EXEC: begin
            state_d  = S_DONE;
            result_d = alu_y;
            c_d      = alu_c;
            n_d      = alu_y[31];
            z_d      = (alu_y == '0);
            v_d      = alu_v;
            done0_d  = ~win_q;
            done1_d  = win_q;
         end
         default: begin
            state_d = S_IDLE;
            rr_d    = win_q;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            done0_d = 1'b0;
            done1_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
`ifdef ALU_ARB_STICKY_OVF_EN
      // Set is applied after clear so a same-cycle set wins.
      if (clr_sticky) sticky_d = 1'b0;
      if ((state_q == S_DONE) && (op_q[2:1] == 2'b11) && v_q) sticky_d = 1'b1;
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         win_q    <= 1'b0;
         rr_q     <= 1'b1;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         result_q <= '0;
         c_q      <= 1'b0;
         n_q      <= 1'b0;
         z_q      <= 1'b0;
         v_q      <= 1'b0;
         busy_q   <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         rr_q     <= rr_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         gnt0_q   <= gnt0_d;
         gnt1_q   <= gnt1_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         result_q <= result_d;
         c_q      <= c_d;
         n_q      <= n_d;
         z_q      <= z_d;
         v_q      <= v_d;
         busy_q   <= busy_d;
         sticky_q <= sticky_d;
      end
   end

   assign bus.gnt0   = gnt0_q;
   assign bus.gnt1   = gnt1_q;
   assign bus.done0  = done0_q;
   assign bus.done1  = done1_q;
   assign bus.result = result_q;
   assign bus.c      = c_q;
   assign bus.n      = n_q;
   assign bus.z      = z_q;
   assign bus.v      = v_q;
   assign bus.busy   = busy_q;

`ifdef ALU_ARB_STICKY_OVF_EN
   assign ovf_sticky = sticky_q;
`else
   logic unused_sticky;
   assign unused_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_alu32_arbiter.sv
// Directed bench for alu32_arbiter: single-requester vector table, then ties,
// reset abort, request-during-EXEC and (with ALU_ARB_STICKY_OVF_EN) sticky overflow.
module tb_alu32_arbiter;
   parameter int unsigned PRIO = 0;

   typedef struct {
      logic        w;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  cnzv;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic exp_sticky = 1'b0;
`ifdef ALU_ARB_STICKY_OVF_EN
   logic clr_sticky = 1'b0;
   logic ovf_sticky;
`endif

   alu32_arbiter_if bus ();

   alu32_arbiter #(.PRIO_MODE(PRIO)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
`ifdef ALU_ARB_STICKY_OVF_EN
      .clr_sticky (clr_sticky),
      .ovf_sticky (ovf_sticky),
`endif
      .bus        (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] flags();
      return {bus.c, bus.n, bus.z, bus.v};
   endfunction

   task automatic chk_sticky(input string name);
`ifdef ALU_ARB_STICKY_OVF_EN
      chk(name, {31'd0, ovf_sticky}, {31'd0, exp_sticky});
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n  = 1'b0;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n    = 1'b1;
      exp_sticky = 1'b0;
   endtask

   // One single-requester transaction; the winner's inputs are scrambled in EXEC
   // to show the operands were captured at grant.
   task automatic do_op(input vec_t t, input string tag);
      @(negedge clk);
      if (t.w) begin
         bus.req1 = 1'b1; bus.op1 = t.op; bus.a1 = t.a; bus.b1 = t.b;
         bus.req0 = 1'b0; bus.op0 = 3'($urandom); bus.a0 = $urandom; bus.b0 = $urandom;
      end else begin
         bus.req0 = 1'b1; bus.op0 = t.op; bus.a0 = t.a; bus.b0 = t.b;
         bus.req1 = 1'b0; bus.op1 = 3'($urandom); bus.a1 = $urandom; bus.b1 = $urandom;
      end
      @(posedge clk); #1;
      chk({tag, " exec gnt"}, {30'd0, bus.gnt1, bus.gnt0}, t.w ? 32'd2 : 32'd1);
      chk({tag, " exec done"}, {30'd0, bus.done1, bus.done0}, 32'd0);
      chk({tag, " exec busy"}, {31'd0, bus.busy}, 32'd1);
      if (t.w) begin bus.a1 = ~t.a; bus.b1 = ~t.b; bus.op1 = t.op ^ 3'b101; end
      else     begin bus.a0 = ~t.a; bus.b0 = ~t.b; bus.op0 = t.op ^ 3'b101; end
      @(posedge clk); #1;
      chk({tag, " done pulse"}, {30'd0, bus.done1, bus.done0}, t.w ? 32'd2 : 32'd1);
      chk({tag, " done gnt"}, {30'd0, bus.gnt1, bus.gnt0}, t.w ? 32'd2 : 32'd1);
      chk({tag, " result"}, bus.result, t.res);
      chk({tag, " cnzv"}, {28'd0, flags()}, {28'd0, t.cnzv});
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      if (t.op[2:1] == 2'b11 && t.cnzv[0]) exp_sticky = 1'b1;
      @(posedge clk); #1;
      chk({tag, " idle busy/gnt/done"},
          {27'd0, bus.busy, bus.gnt1, bus.gnt0, bus.done1, bus.done0}, 32'd0);
      chk({tag, " result held"}, bus.result, t.res);
      chk_sticky({tag, " sticky"});
   endtask

   vec_t vecs[13];

   initial begin
      vecs[0]  = '{1'b0, 3'b111, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b0100};
      vecs[1]  = '{1'b1, 3'b110, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101};
      vecs[2]  = '{1'b1, 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010};
      vecs[3]  = '{1'b0, 3'b000, 32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_0000, 4'b0100};
      vecs[4]  = '{1'b1, 3'b001, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0010};
      vecs[5]  = '{1'b0, 3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0100};
      vecs[6]  = '{1'b1, 3'b011, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 4'b0000};
      vecs[7]  = '{1'b0, 3'b100, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 4'b0100};
      vecs[8]  = '{1'b1, 3'b101, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000, 4'b0010};
      vecs[9]  = '{1'b0, 3'b111, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 4'b1010};
      vecs[10] = '{1'b1, 3'b111, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b1001};
      vecs[11] = '{1'b0, 3'b110, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 4'b0000};
      vecs[12] = '{1'b0, 3'b111, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0100};

      bus.req0 = 1'b0; bus.op0 = '0; bus.a0 = '0; bus.b0 = '0;
      bus.req1 = 1'b0; bus.op1 = '0; bus.a1 = '0; bus.b1 = '0;

      // Reset, then idle with no requests.
      repeat (2) @(posedge clk);
      #1;
      chk("in-reset outputs",
          {27'd0, bus.busy, bus.gnt1, bus.gnt0, bus.done1, bus.done0}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("idle ctrl", {27'd0, bus.busy, bus.gnt1, bus.gnt0, bus.done1, bus.done0}, 32'd0);
         chk("idle result/flags", bus.result | {28'd0, flags()}, 32'd0);
         chk_sticky("idle sticky");
      end

      for (int i = 0; i < 13; i++) begin
         do_op(vecs[i], $sformatf("vec%0d", i));
`ifdef ALU_ARB_STICKY_OVF_EN
         if (i == 1) begin
            @(negedge clk); clr_sticky = 1'b1;
            @(posedge clk); #1; exp_sticky = 1'b0;
            chk_sticky("sticky cleared");
            clr_sticky = 1'b0;
         end
`endif
      end

`ifdef ALU_ARB_STICKY_OVF_EN
      // Clear held across an overflowing op: the DONE-edge set wins.
      @(negedge clk); clr_sticky = 1'b1;
      do_op(vecs[1], "set-wins");
      @(posedge clk); #1; exp_sticky = 1'b0;
      chk_sticky("sticky clr after set");
      clr_sticky = 1'b0;
`endif

      // Both requesters held high from reset.
      do_reset();
      bus.req0 = 1'b1; bus.op0 = 3'b110; bus.a0 = 32'd1; bus.b0 = 32'd1;
      bus.req1 = 1'b1; bus.op1 = 3'b110; bus.a1 = 32'd3; bus.b1 = 32'd3;
      for (int t = 1; t <= 12; t++) begin
         int   ph;
         int   k;
         logic w;
         ph = (t - 1) % 3;
         k  = (t - 1) / 3;
         w  = (PRIO == 1) ? 1'b0 : k[0];
         @(posedge clk); #1;
         chk($sformatf("tie gnt t%0d", t), {30'd0, bus.gnt1, bus.gnt0},
             (ph == 2) ? 32'd0 : (w ? 32'd2 : 32'd1));
         chk($sformatf("tie done t%0d", t), {30'd0, bus.done1, bus.done0},
             (ph != 1) ? 32'd0 : (w ? 32'd2 : 32'd1));
         if (ph == 1) chk($sformatf("tie result t%0d", t), bus.result, w ? 32'd6 : 32'd2);
      end

      // Reset while EXEC: no done, outputs cleared, then re-issue.
      do_reset();
      do_op(vecs[11], "pre-abort");
      @(negedge clk);
      bus.req0 = 1'b1; bus.op0 = 3'b010; bus.a0 = 32'hF0F0_F0F0; bus.b0 = 32'hFF00_FF00;
      @(posedge clk); #1;
      chk("abort exec busy", {31'd0, bus.busy}, 32'd1);
      reset_n  = 1'b0;
      bus.req0 = 1'b0;
      @(posedge clk); #1;
      chk("abort ctrl", {27'd0, bus.busy, bus.gnt1, bus.gnt0, bus.done1, bus.done0}, 32'd0);
      chk("abort result/flags", bus.result | {28'd0, flags()}, 32'd0);
      @(negedge clk); reset_n = 1'b1; exp_sticky = 1'b0;
      @(posedge clk); #1;
      chk("abort no late done", {29'd0, bus.busy, bus.done1, bus.done0}, 32'd0);
      do_op(vecs[5], "reissue");

      // req1 rising during EXEC of req0 is served right after.
      @(negedge clk);
      bus.req0 = 1'b1; bus.op0 = 3'b110; bus.a0 = 32'd1; bus.b0 = 32'd1;
      @(posedge clk); #1;
      bus.req1 = 1'b1; bus.op1 = 3'b110; bus.a1 = 32'd3; bus.b1 = 32'd3;
      @(posedge clk); #1;
      chk("late req done0", {30'd0, bus.done1, bus.done0}, 32'd1);
      bus.req0 = 1'b0;
      @(posedge clk); #1;
      chk("late req idle", {31'd0, bus.busy}, 32'd0);
      @(posedge clk); #1;
      chk("late req gnt1", {30'd0, bus.gnt1, bus.gnt0}, 32'd2);
      bus.req1 = 1'b0;
      @(posedge clk); #1;
      chk("late req done1", {30'd0, bus.done1, bus.done0}, 32'd2);
      chk("late req result", bus.result, 32'd6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   always @(negedge clk) begin
      if (reset_n && (bus.gnt0 === 1'b1) && (bus.gnt1 === 1'b1)) begin
         errors++;
         $display("FAIL gnt exclusive: gnt0=1 gnt1=1 required not both at %0t", $time);
      end
      if (reset_n && (bus.done0 === 1'b1) && (bus.done1 === 1'b1)) begin
         errors++;
         $display("FAIL done exclusive: done0=1 done1=1 required not both at %0t", $time);
      end
   end

endmodule

// File: doc/alu32_arbiter.md
Name: alu32_arbiter

Overview:
- Shares one alu32 instance (32-bit ALU, 3-bit op, flags c/n/z/v) between two requesters.
- Arbitrates, latches the winning operands, sequences one ALU evaluation, and returns a registered result and flags with a one-cycle done pulse to the winner.
- Sits between the two datapath clients and the ALU. The ALU is instantiated inside this block.

Parameters:
- PRIO_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (requester 0 always wins ties).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  synchronous active-low reset
- req0  input  1  requester 0 operation request
- op0  input  3  requester 0 ALU op (000 not a, 001 not b, 010 and, 011 or, 100 xor, 101 xnor, 110 add, 111 sub)
- a0, b0  input  32 each  requester 0 operands
- req1, op1, a1, b1  input  1/3/32/32  requester 1, same meaning
- gnt0, gnt1  output  1 each  winner indication, high in EXEC and DONE
- done0, done1  output  1 each  one-cycle completion pulse to the winner
- result  output  32  registered ALU result of the last completed op
- c, n, z, v  output  1 each  registered ALU flags of the last completed op
- busy  output  1  high whenever state is not IDLE

Behaviour:
- One clock. Reset is synchronous and active-low: when reset_n=0 at a rising edge, state <= IDLE, all outputs <= 0, and the RR pointer <= 1 so requester 0 wins the first tie.
- FSM states:
  - IDLE:
    - No req: stay in IDLE.
    - Any req: select the winner and latch its op/a/b into internal registers. Go to EXEC. Set gnt of the winner.
  - EXEC:
    - The latched registers drive the alu32 inputs.
    - At the clock edge, result/c/n/z/v <= alu32 outputs. Go to DONE.
  - DONE:
    - done of the winner = 1 for exactly this cycle; gnt is held.
    - Update the RR pointer to the winner. Go to IDLE.
- Latency: req sampled high in IDLE at edge k, then EXEC in cycle k+1, then done high in cycle k+2. The result is valid from the done cycle and held until the next completion.
- Throughput: one op per 3 cycles.
- Handshake:
  - A requester holds req/op/a/b stable until its done pulse.
  - Operands are latched at grant, so later changes do not affect the op in flight.
  - Keeping req high after done means a new request, re-arbitrated in IDLE on the next cycle.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high, PRIO_MODE=0: the requester not equal to the RR pointer wins.
  - Both high, PRIO_MODE=1: requester 0 wins.
- A req that rises during EXEC/DONE is ignored until IDLE, with no loss; it is sampled in IDLE.
- Flags are passed through from alu32 exactly as computed, including c/v for non-arithmetic ops. No masking is done here.
- gnt0 and gnt1 are never high together. done0 and done1 are never high together.
- Reset mid-operation (EXEC or DONE): abort, no done pulse, result/flags cleared. The requester must re-issue.

Optional Feature:
- ALU_ARB_STICKY_OVF_EN defined:
  - Adds input clr_sticky (1) and output ovf_sticky (1).
  - ovf_sticky sets on the DONE cycle edge when the completed op is 110/111 with v=1.
  - It is cleared by clr_sticky=1 at a clock edge or by reset. If set and clear occur in the same cycle, set wins.
- Not defined: those ports and that logic are absent. All other behaviour is unchanged.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, then 1 with no req. Required: all outputs 0, busy=0, state stays IDLE.
- req0, op=111, a=5, b=7. Required: gnt0 high in the next 2 cycles; done0 pulses 2 cycles after the sample; result=0xFFFFFFFE, n=1, z=0, c=0, v=0.
- req1, op=110, a=0x7FFFFFFF, b=1. Required: result=0x80000000, n=1, v=1, c=0. With ALU_ARB_STICKY_OVF_EN: ovf_sticky=1 until clr_sticky.
- req1, op=110, a=0xFFFFFFFF, b=1. Required: result=0, z=1, c=1.
- req0 and req1 both high continuously after reset, PRIO_MODE=0. Required: grant order 0,1,0,1, done pulses every 3 cycles, never overlapping. PRIO_MODE=1: always 0.
- Reset during EXEC of op=010 (a=0xF0F0F0F0, b=0xFF00FF00). Required: no done pulse, result=0, IDLE next cycle. Re-issue gives result=0xF000F000.
